// File: rtl/expr_recognizer.sv
// Streaming recognizer for integer arithmetic expressions, one ASCII character per valid cycle.
// Define EXPR_PAREN_EN to enable parenthesis support; otherwise '(' and ')' are syntax errors.
module expr_recognizer #(
  parameter int MAX_DIGITS = 4,
  parameter int MAX_DEPTH  = 7
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] in,
  input  logic       in_valid,
  output logic       out,
  output logic       err,
  output logic [3:0] depth,
  output logic [7:0] num_cnt
);

  // state | meaning
  // START | nothing accepted since reset
  // NUM   | inside an operand
  // OP    | after an operator or '(' ; operand expected
  // CLOSE | after ')'
  // ERR   | syntax error seen, absorbing until reset
  typedef enum logic [2:0] {START, NUM, OP, CLOSE, ERR} state_t;

  localparam logic [3:0] MAX_DIGITS_L = 4'(MAX_DIGITS);
  localparam logic [3:0] MAX_DEPTH_L  = 4'(MAX_DEPTH);

  state_t     state, state_nx;
  logic [3:0] dig_cnt, dig_cnt_nx;
  logic [3:0] depth_q, depth_nx;
  logic [7:0] num_cnt_q, num_cnt_nx;
  logic       out_q, out_nx;
  logic       is_digit, is_op, is_open, is_close;

  always_comb begin
    is_digit = (in >= 8'h30) && (in <= 8'h39);
    is_op    = (in == 8'h2B) || (in == 8'h2D) || (in == 8'h2A) || (in == 8'h2F);
`ifdef EXPR_PAREN_EN
    is_open  = (in == 8'h28);
    is_close = (in == 8'h29);
`else
    is_open  = 1'b0;
    is_close = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= START;
      dig_cnt   <= 4'd0;
      depth_q   <= 4'd0;
      num_cnt_q <= 8'd0;
      out_q     <= 1'b0;
    end else begin
      state     <= state_nx;
      dig_cnt   <= dig_cnt_nx;
      depth_q   <= depth_nx;
      num_cnt_q <= num_cnt_nx;
      out_q     <= out_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    dig_cnt_nx = dig_cnt;
    depth_nx   = depth_q;
    num_cnt_nx = num_cnt_q;
    out_nx     = out_q;
    if (in_valid && (state != ERR)) begin
      case (state)
        START, OP: begin
          if (is_digit) begin
            state_nx   = NUM;
            dig_cnt_nx = 4'd1;
            if (num_cnt_q != 8'hFF) num_cnt_nx = num_cnt_q + 8'd1;
          end else if (is_open && (depth_q < MAX_DEPTH_L)) begin
            depth_nx = depth_q + 4'd1;
            state_nx = OP;
          end else begin
            state_nx = ERR;
          end
        end
        NUM: begin
          if (is_digit) begin
            if (dig_cnt < MAX_DIGITS_L) dig_cnt_nx = dig_cnt + 4'd1;
            else state_nx = ERR;
          end else if (is_op) begin
            state_nx = OP;
          end else if (is_close && (depth_q != 4'd0)) begin
            depth_nx = depth_q - 4'd1;
            state_nx = CLOSE;
          end else begin
            state_nx = ERR;
          end
        end
        CLOSE: begin
          if (is_op) begin
            state_nx = OP;
          end else if (is_close && (depth_q != 4'd0)) begin
            depth_nx = depth_q - 4'd1;
          end else begin
            state_nx = ERR;
          end
        end
        default: state_nx = ERR;
      endcase
      // depth_nx/num_cnt_nx are untouched on every path into ERR, so they freeze there
      out_nx = ((state_nx == NUM) || (state_nx == CLOSE)) && (depth_nx == 4'd0);
    end
  end

  assign out     = out_q;
  assign err     = (state == ERR);
  assign depth   = depth_q;
  assign num_cnt = num_cnt_q;

endmodule

// File: tb/tb_expr_recognizer.sv
// Randomized bench for expr_recognizer against a character-history grammar model,
// plus directed scenarios with literal expectations.
module tb_expr_recognizer;
  localparam int MD = 4;
  localparam int MP = 2;
`ifdef EXPR_PAREN_EN
  localparam bit PAREN = 1'b1;
`else
  localparam bit PAREN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in = 8'h00;
  logic       out, err;
  logic [3:0] depth;
  logic [7:0] num_cnt;

  int vectors = 0;
  int miscompares = 0;

  expr_recognizer #(.MAX_DIGITS(MD), .MAX_DEPTH(MP)) dut (
    .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
    .out(out), .err(err), .depth(depth), .num_cnt(num_cnt)
  );

  always #5 clk = ~clk;

  // Model: remembers only the last accepted character, current digit run,
  // open-paren count, operand count and error flag.
  byte m_last  = 0;
  int  m_run   = 0;
  int  m_depth = 0;
  int  m_cnt   = 0;
  bit  m_err   = 0;

  function automatic bit is_dig(byte c);
    return (c >= "0") && (c <= "9");
  endfunction

  function automatic bit operand_end(byte c);
    return is_dig(c) || (PAREN && (c == ")"));
  endfunction

  always @(posedge clk or negedge clr) begin
    byte c;
    bit  ok;
    if (!clr) begin
      m_last = 0; m_run = 0; m_depth = 0; m_cnt = 0; m_err = 0;
    end else if (in_valid && !m_err) begin
      c  = in;
      ok = 0;
      if (is_dig(c)) begin
        if (is_dig(m_last)) begin
          ok = (m_run < MD);
          if (ok) m_run++;
        end else begin
          ok = !operand_end(m_last);
          if (ok) begin
            m_run = 1;
            if (m_cnt < 255) m_cnt++;
          end
        end
      end else if (c inside {"+", "-", "*", "/"}) begin
        ok = operand_end(m_last);
      end else if (PAREN && (c == "(")) begin
        ok = !operand_end(m_last) && (m_depth < MP);
        if (ok) m_depth++;
      end else if (PAREN && (c == ")")) begin
        ok = operand_end(m_last) && (m_depth > 0);
        if (ok) m_depth--;
      end
      if (ok) m_last = c;
      else m_err = 1;
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit eo;
    eo = !m_err && operand_end(m_last) && (m_depth == 0);
    chk("model_out", 32'(out), 32'(eo));
    chk("model_err", 32'(err), 32'(m_err));
    chk("model_depth", 32'(depth), 32'(m_depth));
    chk("model_num_cnt", 32'(num_cnt), 32'(m_cnt));
  end

  // Called and returns at posedge+2; the character is consumed at the next posedge.
  task automatic step(byte c, bit v);
    in = c;
    in_valid = v;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    clr = 1'b0;
    @(posedge clk);
    #2;
    clr = 1'b1;
  endtask

  task automatic send(string s);
    for (int i = 0; i < s.len(); i++) step(s[i], 1'b1);
  endtask

  task automatic send_chk_out(string name, string s, string exp_out);
    for (int i = 0; i < s.len(); i++) begin
      step(s[i], 1'b1);
      chk(name, 32'(out), 32'(exp_out[i] == "1"));
    end
  endtask

  initial begin
    string pool;
    pool = "0123456789+-*/()a ";
    @(posedge clk);
    #2;
    chk("reset_out", 32'(out), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_depth", 32'(depth), 32'd0);
    chk("reset_num_cnt", 32'(num_cnt), 32'd0);
    clr = 1'b1;

    send_chk_out("s1_out", "12+3*45", "1101011");
    chk("s1_err", 32'(err), 32'd0);
    chk("s1_num_cnt", 32'(num_cnt), 32'd3);

    do_reset();
    send_chk_out("s2_out", "1234", "1111");
    step("5", 1'b1);
    chk("s2_err", 32'(err), 32'd1);
    chk("s2_out5", 32'(out), 32'd0);
    chk("s2_num_cnt", 32'(num_cnt), 32'd1);

`ifdef EXPR_PAREN_EN
    begin
      string s3;
      int    d3 [9];
      s3 = "(1+(2))*3";
      d3 = '{1, 1, 1, 2, 2, 1, 0, 0, 0};
      do_reset();
      for (int i = 0; i < 9; i++) begin
        step(s3[i], 1'b1);
        chk("s3_depth", 32'(depth), 32'(d3[i]));
        chk("s3_out", 32'(out), 32'((i == 6) || (i == 8)));
      end
      chk("s3_err", 32'(err), 32'd0);
    end
`endif

    foreach (pool[i]) begin end
    begin
      string bad [4];
      bad = '{"+1", ")", "1(", "1+*"};
      for (int k = 0; k < 4; k++) begin
        do_reset();
        send(bad[k]);
        chk("s4_err", 32'(err), 32'd1);
        send("1)");
        chk("s4_err_hold", 32'(err), 32'd1);
        chk("s4_out_hold", 32'(out), 32'd0);
      end
    end

    do_reset();
    send("1+2");
    for (int i = 0; i < 3; i++) begin
      step("*", 1'b0);
      chk("s5_hold_out", 32'(out), 32'd1);
      chk("s5_hold_num_cnt", 32'(num_cnt), 32'd2);
    end
    clr = 1'b0;
    #1;
    chk("s5_async_out", 32'(out), 32'd0);
    chk("s5_async_err", 32'(err), 32'd0);
    chk("s5_async_depth", 32'(depth), 32'd0);
    chk("s5_async_num_cnt", 32'(num_cnt), 32'd0);
    @(posedge clk);
    #2;
    clr = 1'b1;
    step("7", 1'b1);
    chk("s5_restart_out", 32'(out), 32'd1);
    chk("s5_restart_num_cnt", 32'(num_cnt), 32'd1);

    do_reset();
    step("(", 1'b1);
    chk("s6_err1", 32'(err), 32'(!PAREN));
    step("(", 1'b1);
    chk("s6_err2", 32'(err), 32'(!PAREN));
    step("(", 1'b1);
    chk("s6_err3", 32'(err), 32'd1);
    chk("s6_depth", 32'(depth), 32'(PAREN ? 2 : 0));

    do_reset();
    for (int i = 0; i < 256; i++) send("1+");
    step("9", 1'b1);
    chk("sat_num_cnt", 32'(num_cnt), 32'd255);
    chk("sat_out", 32'(out), 32'd1);

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ((err && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 80) == 0)) do_reset();
      step(pool[$urandom_range(0, pool.len() - 1)], ($urandom_range(0, 3) != 0));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/expr_recognizer.md
EXPR_RECOGNIZER -- requirements
Module: expr_recognizer

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 4, meaning the maximum number of digits per operand (legal range 1..15).
REQ-002 SHALL have parameter MAX_DEPTH, default 7, meaning the maximum parenthesis nesting depth (legal range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port clr, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in, input, 8 bits: ASCII character.
REQ-006 SHALL have port in_valid, input, 1 bit: the character on in is consumed on a rising clk edge only when in_valid=1.
REQ-007 SHALL have port out, output, 1 bit: the accepted prefix is a complete, well-formed expression.
REQ-008 SHALL have port err, output, 1 bit: sticky syntax error.
REQ-009 SHALL have port depth, output, 4 bits: current open-parenthesis count.
REQ-010 SHALL have port num_cnt, output, 8 bits: operands accepted so far, saturating at 255.

Function
REQ-011 SHALL classify in as exactly one of: digit ('0'..'9'), operator ('+','-','*','/'), open ('('), close (')'), or other.
REQ-012 SHALL implement five states: START, NUM, OP, CLOSE and ERR.
REQ-013 In START or OP: a digit SHALL go to NUM, set the digit count to 1 and increment num_cnt; open with depth<MAX_DEPTH SHALL increment depth and go to OP; open with depth=MAX_DEPTH, or any other class, SHALL go to ERR.
REQ-014 In NUM: a digit with digit count<MAX_DIGITS SHALL stay in NUM and increment the count, and a digit at MAX_DIGITS SHALL go to ERR; an operator SHALL go to OP; close with depth>0 SHALL decrement depth and go to CLOSE, and close at depth 0 SHALL go to ERR; open or other SHALL go to ERR.
REQ-015 In CLOSE: an operator SHALL go to OP; close with depth>0 SHALL decrement depth and stay in CLOSE, and close at depth 0 SHALL go to ERR; digit, open or other SHALL go to ERR.
REQ-016 ERR SHALL be absorbing: it ignores all input until reset, and err=1 while in ERR.
REQ-017 out SHALL be registered: out=1 exactly when the state is NUM or CLOSE, depth=0 and err=0, visible the cycle after the accepting edge (latency 1).
REQ-018 When in_valid=0, state, digit count, depth, num_cnt, out and err SHALL all hold.
REQ-019 num_cnt SHALL increment on the first digit of each operand only, and SHALL stay at 255 once reached.
REQ-020 On entry to ERR, depth and num_cnt SHALL freeze at their last values and out SHALL drop to 0 in the same cycle err rises.

Reset
REQ-021 clr=0 SHALL immediately and asynchronously force state=START, digit count=0, depth=0, num_cnt=0, out=0 and err=0, including mid-expression and from ERR.
REQ-022 The first character accepted after clr returns high SHALL be processed as the start of a new expression.

Configuration
REQ-023 Macro EXPR_PAREN_EN SHALL control parenthesis support.
REQ-024 With EXPR_PAREN_EN defined: REQ-013 to REQ-015 apply in full.
REQ-025 Without EXPR_PAREN_EN: open and close SHALL be classified as other (go to ERR), depth SHALL be constant 0, CLOSE SHALL be unreachable, and MAX_DEPTH SHALL be ignored.

Verification
REQ-026 Scenario 1: "12+3*45" with in_valid=1 each cycle -> out sequence 1,1,0,1,0,1,1; err=0; num_cnt=3.
REQ-027 Scenario 2: with MAX_DIGITS=4, "12345" -> out=1 for 4 cycles, then err=1 and out=0 after the fifth character; num_cnt=1.
REQ-028 Scenario 3 (EXPR_PAREN_EN): "(1+(2))*3" -> depth sequence 1,1,1,2,2,1,0,0,0; out=1 only after the second ')' and after the final '3'; err=0.
REQ-029 Scenario 4: "+1", ")", "1(" and "1+*" -> each yields err=1; any further input leaves err=1 and out=0.
REQ-030 Scenario 5: "1+2", then in_valid=0 for 3 cycles with in="*" -> outputs hold (out=1, num_cnt=2); then clr low mid-cycle -> all outputs 0 without a clk edge.
REQ-031 Scenario 6 (EXPR_PAREN_EN, MAX_DEPTH=2): "(((" -> err=1 on the third '('; the same stimulus without the macro -> err=1 on the first '('.
